psum_accumulator: RTL and testbench

Downstream consumer of the output FIFO (ofifo) behind the MAC array. It pops one row of `col` per-column partial sums at a time and accumulates them across kernel passes (kij) into an on-chip psum buffer indexed by nij. After the final pass it streams the results out through ReLU on a valid/ready interface toward SRAM writeback.

---
 rtl/psum_accumulator_if.sv | 29 ++
 rtl/psum_accumulator.sv | 145 ++++++++++++++
 tb/tb_psum_accumulator.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_if.sv
// Control, ofifo-side and writeback-side signals of psum_accumulator bundled as one interface.
// The slave modport is the accumulator; the master modport is whoever drives it.
interface psum_accumulator_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic                     start;
    logic [7:0]               num_nij;
    logic                     first_kij;
    logic                     last_kij;
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     out_valid;
    logic [psum_bw*col-1:0]   out_data;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    modport master (
        output start, num_nij, first_kij, last_kij, ofifo_valid, ofifo_out, out_ready,
        input  ofifo_rd, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, num_nij, first_kij, last_kij, ofifo_valid, ofifo_out, out_ready,
        output ofifo_rd, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates ofifo psum rows across kij passes into an nij-indexed buffer, then drains it through ReLU.
// Define PSUM_SAT_EN to make each lane add saturate instead of wrapping.
module psum_accumulator #(
    parameter int col       = 8,
    parameter int psum_bw   = 16,
    parameter int nij_depth = 64,
    parameter int addr_bw   = 6
) (
    input  logic               clk,
    input  logic               reset,
    psum_accumulator_if.slave  bus
);
    localparam int ROW_W = col * psum_bw;
    localparam int N_W   = addr_bw + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [addr_bw-1:0]   idx_q, idx_d;
    logic [N_W-1:0]       n_q, n_d, n_clip;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 mem_we;
    logic                 is_last_row;
    logic [ROW_W-1:0]     cur_row, acc_row, relu_row;

    // Not reset: contents survive across passes and are only initialised by a first_kij pass.
    logic [ROW_W-1:0]     psum_mem_q [nij_depth];

    assign cur_row     = psum_mem_q[idx_q];
    assign is_last_row = ({1'b0, idx_q} == (n_q - N_W'(1)));
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;

    always_comb begin
        if (int'(bus.num_nij) > nij_depth) n_clip = N_W'(nij_depth);
        else                               n_clip = N_W'(bus.num_nij);
    end

    for (genvar c = 0; c < col; c++) begin : g_lane
        logic signed [psum_bw-1:0] stored, op_a, op_b, sum_raw;
        assign stored  = cur_row[c*psum_bw +: psum_bw];
        assign op_a    = first_q ? '0 : stored;
        assign op_b    = bus.ofifo_out[c*psum_bw +: psum_bw];
        assign sum_raw = op_a + op_b;
`ifdef PSUM_SAT_EN
        // Overflow only when both operands share a sign that the result does not.
        logic ovf;
        assign ovf = (op_a[psum_bw-1] == op_b[psum_bw-1]) && (sum_raw[psum_bw-1] != op_a[psum_bw-1]);
        assign acc_row[c*psum_bw +: psum_bw] = !ovf ? sum_raw :
                                               op_a[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                               : {1'b0, {(psum_bw-1){1'b1}}};
`else
        assign acc_row[c*psum_bw +: psum_bw] = sum_raw;
`endif
        assign relu_row[c*psum_bw +: psum_bw] = stored[psum_bw-1] ? '0 : stored;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        n_d           = n_q;
        first_d       = first_q;
        last_d        = last_q;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        bus.ofifo_rd  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d     = n_clip;
                    first_d = bus.first_kij;
                    last_d  = bus.last_kij;
                    idx_d   = '0;
                    if (n_clip != '0)       state_d = ACCUM;
                    else if (bus.last_kij)  state_d = DRAIN;
                    else                    done_d  = 1'b1;
                end
            end
            ACCUM: begin
                // A row arriving while reset is high is left in the ofifo and not written.
                bus.ofifo_rd = bus.ofifo_valid && !reset;
                if (bus.ofifo_valid) begin
                    mem_we = 1'b1;
                    if (is_last_row) begin
                        idx_d = '0;
                        if (last_q) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + addr_bw'(1);
                    end
                end
            end
            DRAIN: begin
                // An empty last pass has nothing to present and finishes straight away.
                if (n_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = relu_row;
                    if (bus.out_ready) begin
                        if (is_last_row) begin
                            idx_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + addr_bw'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) psum_mem_q[idx_q] <= acc_row;
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised scoreboard bench for psum_accumulator against a plain-arithmetic model of the psum buffer.
// Honours PSUM_SAT_EN the same way as the design.
module tb_psum_accumulator;
    localparam int COL     = 8;
    localparam int BW      = 16;
    localparam int DEPTH   = 64;
    localparam int ADDR_BW = 6;
    localparam int ROW_W   = COL * BW;
    localparam int MAXV    = (1 << (BW - 1)) - 1;
    localparam int MINV    = -(1 << (BW - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_accumulator_if #(.col(COL), .psum_bw(BW)) bus ();

    psum_accumulator #(.col(COL), .psum_bw(BW), .nij_depth(DEPTH), .addr_bw(ADDR_BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [ROW_W-1:0] fifo_q[$];
    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] stim_rows[$];
    bit               valid_pat[$];
    bit               ready_pat[$];
    bit               gap_en = 1'b0;
    bit               rand_ready = 1'b0;

    int  model_mem [DEPTH][COL];

    int               cyc = 0;
    int               pops_total = 0;
    int               last_pop_cycle = 0;
    bit               done_seen = 1'b0;
    int               done_cycle = 0;
    bit               busy_at_done = 1'b0;
    logic             snap_busy, snap_done, snap_valid, snap_rd;
    logic [ROW_W-1:0] snap_data;
    int               valid_cycles = 0;

    task automatic checkOutput(input string name, input logic [ROW_W-1:0] actual,
                               input logic [ROW_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int fold(input int s);
        int r;
`ifdef PSUM_SAT_EN
        r = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
`else
        r = s % (1 << BW);
        if (r < 0) r += (1 << BW);
        if (r > MAXV) r -= (1 << BW);
`endif
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic step_cycle();
        bit pop_now;
        bit v;
        @(negedge clk);
        cyc++;
        snap_busy  = bus.busy;
        snap_done  = bus.done;
        snap_valid = bus.out_valid;
        snap_rd    = bus.ofifo_rd;
        snap_data  = bus.out_data;
        pop_now    = bus.ofifo_rd && bus.ofifo_valid;
        if (pop_now) begin
            pops_total++;
            last_pop_cycle = cyc;
        end
        if (bus.done) begin
            done_seen    = 1'b1;
            done_cycle   = cyc;
            busy_at_done = bus.busy;
        end
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (valid_pat.size() > 0) v = valid_pat.pop_front();
        else if (gap_en)          v = ($urandom_range(0, 3) != 0);
        else                      v = 1'b1;
        bus.ofifo_valid = v && (fifo_q.size() > 0);
        bus.ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (ready_pat.size() > 0) bus.out_ready = ready_pat.pop_front();
        else if (rand_ready)      bus.out_ready = ($urandom_range(0, 2) != 0);
        else                      bus.out_ready = 1'b1;
    endtask

    // Issues one pass: loads the ofifo, updates the model, queues expected drain rows and waits for done.
    task automatic applyStimulus(input int num, input bit first, input bit last,
                                 input bit chk_lat, input int spur_iter);
        int               n_eff;
        int               pops_before;
        int               start_cyc;
        int               v;
        logic [ROW_W-1:0] row;
        n_eff = (num > DEPTH) ? DEPTH : num;
        for (int r = 0; r < n_eff; r++) begin
            row = (stim_rows.size() > 0) ? stim_rows.pop_front() : rand_row();
            fifo_q.push_back(row);
            for (int c = 0; c < COL; c++)
                model_mem[r][c] = fold((first ? 0 : model_mem[r][c]) + int'($signed(row[c*BW +: BW])));
        end
        if (last) begin
            for (int r = 0; r < n_eff; r++) begin
                for (int c = 0; c < COL; c++) begin
                    v = (model_mem[r][c] < 0) ? 0 : model_mem[r][c];
                    row[c*BW +: BW] = v[BW-1:0];
                end
                exp_q.push_back(row);
            end
        end
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        bus.num_nij     = num[7:0];
        bus.first_kij   = first;
        bus.last_kij    = last;
        bus.start       = 1'b1;
        done_seen       = 1'b0;
        pops_before     = pops_total;
        step_cycle();
        start_cyc = cyc;
        bus.start = 1'b0;
        for (int i = 1; i <= 2000 && !done_seen; i++) begin
            step_cycle();
            if (i == spur_iter) begin
                bus.start     = 1'b1;
                bus.num_nij   = 8'd1;
                bus.first_kij = !first;
                bus.last_kij  = !last;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checkOutput("done_seen", done_seen, 1);
        if (done_seen) begin
            checkOutput("busy_at_done", busy_at_done, 0);
            checkOutput("pop_count", pops_total - pops_before, n_eff);
            if (!last && n_eff > 0) checkOutput("done_after_pop", done_cycle, last_pop_cycle + 1);
            if (chk_lat) checkOutput("pass_latency", done_cycle - start_cyc, last ? 2*n_eff + 1 : n_eff + 1);
            if (last) checkOutput("rows_left", exp_q.size(), 0);
            step_cycle();
            checkOutput("done_pulse_width", snap_done, 0);
        end else begin
            reset = 1'b1;
            repeat (2) step_cycle();
            reset = 1'b0;
            fifo_q.delete();
            exp_q.delete();
            step_cycle();
        end
    endtask

    // Scoreboard monitor: pops one expected row per handshake and checks rows hold steady under backpressure.
    logic [ROW_W-1:0] held_data;
    bit               stall_pending = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checkOutput("stall_valid", bus.out_valid, 1);
                checkOutput("stall_data", bus.out_data, held_data);
            end
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_row: got %0h, expected no row", bus.out_data);
                end else begin
                    checkOutput("drain_row", bus.out_data, exp_q.pop_front());
                end
            end
            stall_pending = bus.out_valid && !bus.out_ready;
            held_data     = bus.out_data;
        end
    end

    initial begin
        logic [ROW_W-1:0] r;
        logic [6:0]       vpat;
        logic [7:0]       rpat;
        int               v0;
        int               pops_before;
        int               num;
        int               passes;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.num_nij     = '0;
        bus.first_kij   = 1'b0;
        bus.last_kij    = 1'b0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out   = '0;
        bus.out_ready   = 1'b1;
        repeat (3) step_cycle();
        checkOutput("reset_busy", snap_busy, 0);
        checkOutput("reset_done", snap_done, 0);
        checkOutput("reset_out_valid", snap_valid, 0);
        checkOutput("reset_ofifo_rd", snap_rd, 0);
        checkOutput("reset_out_data", snap_data, 0);
        reset = 1'b0;
        step_cycle();

        $display("[TB] two-pass accumulate and drain");
        for (int i = 0; i < 4; i++) begin
            r = rand_row();
            r[0 +: BW] = BW'(10 * (i + 1));
            stim_rows.push_back(r);
        end
        applyStimulus(4, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            r = rand_row();
            r[0 +: BW] = BW'(i + 1);
            stim_rows.push_back(r);
        end
        applyStimulus(4, 1'b0, 1'b1, 1'b1, 0);

        $display("[TB] relu");
        r = '0;
        r[3*BW +: BW] = BW'(-5);
        r[4*BW +: BW] = BW'(7);
        stim_rows.push_back(r);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 0);

        $display("[TB] backpressure");
        applyStimulus(4, 1'b1, 1'b0, 1'b0, 0);
        rpat = 8'b0001_1111;
        for (int i = 0; i < 8; i++) ready_pat.push_back(rpat[i]);
        applyStimulus(4, 1'b0, 1'b1, 1'b0, 0);

        $display("[TB] ofifo gaps and ignored start");
        vpat = 7'b1011001;
        for (int i = 0; i < 7; i++) valid_pat.push_back(vpat[i]);
        applyStimulus(4, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(4, 1'b0, 1'b1, 1'b1, 0);

        $display("[TB] overflow");
        r = '0;
        r[0 +: BW] = BW'(MAXV);
        stim_rows.push_back(r);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 0);
        r = '0;
        r[0 +: BW] = BW'(1);
        stim_rows.push_back(r);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 0);

        $display("[TB] empty passes");
        v0 = valid_cycles;
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("empty_no_valid", valid_cycles - v0, 0);

        $display("[TB] reset mid-pass");
        for (int i = 0; i < 4; i++) fifo_q.push_back(rand_row());
        for (int i = 0; i < 6; i++) valid_pat.push_back(i < 2);
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out   = fifo_q[0];
        bus.num_nij     = 8'd4;
        bus.first_kij   = 1'b1;
        bus.last_kij    = 1'b1;
        bus.start       = 1'b1;
        pops_before     = pops_total;
        step_cycle();
        bus.start = 1'b0;
        repeat (2) step_cycle();
        reset     = 1'b1;
        bus.start = 1'b1;
        step_cycle();
        reset     = 1'b0;
        bus.start = 1'b0;
        step_cycle();
        checkOutput("midreset_pops", pops_total - pops_before, 2);
        checkOutput("midreset_busy", snap_busy, 0);
        checkOutput("midreset_done", snap_done, 0);
        checkOutput("midreset_out_valid", snap_valid, 0);
        checkOutput("midreset_ofifo_rd", snap_rd, 0);
        checkOutput("midreset_out_data", snap_data, 0);
        fifo_q.delete();
        valid_pat.delete();
        applyStimulus(4, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(4, 1'b0, 1'b1, 1'b1, 0);

        $display("[TB] random jobs");
        gap_en     = 1'b1;
        rand_ready = 1'b1;
        for (int job = 0; job < 5; job++) begin
            num    = $urandom_range(1, 90);
            passes = $urandom_range(1, 3);
            for (int p = 0; p < passes; p++)
                applyStimulus(num, p == 0, p == passes - 1, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
